// File: rtl/mux_scan_ctrl.sv
// Scan controller for a downstream 4:1 mux: steps the select code a->d, holds each
// select for HOLD_CYCLES clocks, captures one bit per select and offers the 4-bit word.
module mux_scan_ctrl #(
    parameter int HOLD_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       mux_out,
    input  logic       ready,
    output logic [1:0] sel,
    output logic       busy,
    output logic [3:0] word,
    output logic       valid,
    output logic [1:0] fsm_state
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SCAN = 2'b01,
        OUT  = 2'b10
    } state_t;

    localparam logic [3:0] LAST = 4'(HOLD_CYCLES - 1);

    state_t     state, state_n;
    logic [3:0] cnt, cnt_n;
    logic [1:0] sel_n;
    logic       busy_n;
    logic       valid_n;
    logic [3:0] word_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
            sel   <= 2'b00;
            busy  <= 1'b0;
            valid <= 1'b0;
            word  <= 4'b0000;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            sel   <= sel_n;
            busy  <= busy_n;
            valid <= valid_n;
            word  <= word_n;
        end
    end

    // Output handshake: word is offered while valid is high and is consumed at the
    // rising edge where valid && ready; until then word and valid stay frozen and
    // start is ignored. A start at the consuming edge launches the next scan directly.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sel_n   = sel;
        busy_n  = busy;
        valid_n = valid;
        word_n  = word;
        case (state)
            IDLE: begin
                sel_n   = 2'b00;
                cnt_n   = 4'd0;
                busy_n  = 1'b0;
                valid_n = 1'b0;
                if (start) begin
                    state_n = SCAN;
                    busy_n  = 1'b1;
                end
            end
            SCAN: begin
                if (cnt < LAST) begin
                    cnt_n = cnt + 4'd1;
                end else begin
                    cnt_n       = 4'd0;
                    word_n[sel] = mux_out;
                    if (sel != 2'b11) begin
                        sel_n = sel + 2'b01;
                    end else begin
                        state_n = OUT;
                        sel_n   = 2'b00;
                        busy_n  = 1'b0;
                        valid_n = 1'b1;
                    end
                end
            end
            OUT: begin
                if (ready) begin
                    valid_n = 1'b0;
                    sel_n   = 2'b00;
                    cnt_n   = 4'd0;
                    if (start) begin
                        state_n = SCAN;
                        busy_n  = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = 4'd0;
                sel_n   = 2'b00;
                busy_n  = 1'b0;
                valid_n = 1'b0;
            end
        endcase
    end

    assign fsm_state = state;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: one instance with HOLD_CYCLES=1 and one with HOLD_CYCLES=3,
// checked cycle by cycle against a timing/word model derived from the scan rules.
module tb_mux_scan_ctrl;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n = 1'b1;
    logic       start   = 1'b0;
    logic       ready   = 1'b0;
    logic [3:0] pat1    = 4'b0000;
    logic [3:0] pat3    = 4'b0000;

    logic [1:0] sel1, sel3, st1, st3;
    logic       busy1, busy3, valid1, valid3;
    logic [3:0] word1, word3;
    logic       mux1, mux3;

    // downstream muxes: a,b,c,d = pat[0..3]
    assign mux1 = pat1[sel1];
    assign mux3 = pat3[sel3];

    mux_scan_ctrl #(.HOLD_CYCLES(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start), .mux_out(mux1), .ready(ready),
        .sel(sel1), .busy(busy1), .word(word1), .valid(valid1), .fsm_state(st1)
    );

    mux_scan_ctrl #(.HOLD_CYCLES(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .start(start), .mux_out(mux3), .ready(ready),
        .sel(sel3), .busy(busy3), .word(word3), .valid(valid3), .fsm_state(st3)
    );

    int errors = 0;
    int checks = 0;
    logic [3:0] exp_q[$];

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic get(input int which, output logic [7:0] obs);
        if (which == 1) obs = {sel1, busy1, valid1, word1};
        else            obs = {sel3, busy3, valid3, word3};
    endtask

    task automatic set_pat(input int which, input logic [3:0] pat);
        if (which == 1) pat1 = pat;
        else            pat3 = pat;
    endtask

    task automatic do_reset();
        start   = 1'b0;
        ready   = 1'b0;
        reset_n = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
    endtask

    // Observes a scan from the start edge (n=0) to the valid cycle (n=4h).
    // Expected: sel = n/h, bit i captured once n >= (i+1)*h, valid exactly at n=4h.
    task automatic run_scan(input int which, input int h, input logic [3:0] pat,
                            input logic [3:0] prev, input bit rand_start);
        logic [7:0] obs, exp_v;
        logic [3:0] ew, got;
        set_pat(which, pat);
        for (int n = 0; n <= 4 * h; n++) begin
            if (n < 4 * h) begin
                for (int i = 0; i < 4; i++)
                    ew[i] = (n >= (i + 1) * h) ? pat[i] : prev[i];
                exp_v = {2'(n / h), 1'b1, 1'b0, ew};
            end else begin
                exp_v = {2'b00, 1'b0, 1'b1, pat};
            end
            get(which, obs);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL scan_h%0d n=%0d {sel,busy,valid,word}: got %b want %b", h, n, obs, exp_v);
            end
            if (n < 4 * h) begin
                start = rand_start ? 1'($urandom_range(0, 1)) : 1'b0;
                ready = 1'($urandom_range(0, 1));
                tick();
            end
        end
        start = 1'b0;
        ready = 1'b0;
        got = obs[3:0];
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: result %b arrived with nothing expected", got);
        end else begin
            ew = exp_q.pop_front();
            if (got !== ew) begin
                errors++;
                $display("FAIL scoreboard word: got %b want %b", got, ew);
            end
        end
    endtask

    task automatic consume_to_idle(input int which, input logic [3:0] pat);
        logic [7:0] obs;
        ready = 1'b1;
        start = 1'b0;
        tick();
        ready = 1'b0;
        get(which, obs);
        checks++;
        if (obs !== {2'b00, 1'b0, 1'b0, pat}) begin
            errors++;
            $display("FAIL consume: got %b want %b", obs, {2'b00, 1'b0, 1'b0, pat});
        end
    endtask

    task automatic launch(input int which, input logic [3:0] pat);
        set_pat(which, pat);
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_q.push_back(pat);
    endtask

    // scenarios
    task automatic test_reset();
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({sel1, busy1, valid1, word1} !== 8'h00) begin
            errors++;
            $display("FAIL reset_h1: got %b want 00000000", {sel1, busy1, valid1, word1});
        end
        checks++;
        if ({sel3, busy3, valid3, word3} !== 8'h00) begin
            errors++;
            $display("FAIL reset_h3: got %b want 00000000", {sel3, busy3, valid3, word3});
        end
        repeat (2) tick();
        reset_n = 1'b1;
    endtask

    task automatic test_fixed();
        launch(1, 4'b1101);
        run_scan(1, 1, 4'b1101, 4'b0000, 1'b0);
        consume_to_idle(1, 4'b1101);
        do_reset();
        launch(3, 4'b0110);
        run_scan(3, 3, 4'b0110, 4'b0000, 1'b0);
        consume_to_idle(3, 4'b0110);
    endtask

    task automatic test_hold_out();
        logic [3:0] pat;
        logic [7:0] obs;
        do_reset();
        pat = 4'($urandom_range(0, 15));
        launch(1, pat);
        run_scan(1, 1, pat, 4'b0000, 1'b0);
        for (int c = 0; c < 5; c++) begin
            ready = 1'b0;
            start = 1'(c % 2 == 0);
            tick();
            get(1, obs);
            checks++;
            if (obs !== {2'b00, 1'b0, 1'b1, pat}) begin
                errors++;
                $display("FAIL hold_out c=%0d: got %b want %b", c, obs, {2'b00, 1'b0, 1'b1, pat});
            end
        end
        consume_to_idle(1, pat);
        tick();
        get(1, obs);
        checks++;
        if (obs !== {2'b00, 1'b0, 1'b0, pat}) begin
            errors++;
            $display("FAIL idle_after_consume: got %b want %b", obs, {2'b00, 1'b0, 1'b0, pat});
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] pa, pb;
        do_reset();
        pa = 4'($urandom_range(0, 15));
        pb = ~pa;
        launch(1, pa);
        run_scan(1, 1, pa, 4'b0000, 1'b0);
        ready = 1'b1;
        launch(1, pb);
        ready = 1'b0;
        run_scan(1, 1, pb, pa, 1'b0);
        consume_to_idle(1, pb);
    endtask

    task automatic test_async_reset();
        logic [3:0] pat;
        logic [7:0] obs;
        do_reset();
        pat = 4'($urandom_range(0, 15));
        launch(1, pat);
        tick();
        tick();
        checks++;
        if (sel1 !== 2'b10) begin
            errors++;
            $display("FAIL pre_reset_sel: got %b want 10", sel1);
        end
        #3 reset_n = 1'b0;
        #1;
        checks++;
        if ({sel1, busy1, valid1, word1} !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: got %b want 00000000", {sel1, busy1, valid1, word1});
        end
        #2 reset_n = 1'b1;
        void'(exp_q.pop_back());
        for (int c = 0; c < 10; c++) begin
            tick();
            get(1, obs);
            checks++;
            if (obs !== 8'h00) begin
                errors++;
                $display("FAIL post_reset c=%0d: got %b want 00000000", c, obs);
            end
        end
    endtask

    task automatic test_random();
        int which, h;
        logic [3:0] pat;
        for (int it = 0; it < 6; it++) begin
            do_reset();
            which = ($urandom_range(0, 1) == 0) ? 1 : 3;
            h = which;
            pat = 4'($urandom_range(0, 15));
            launch(which, pat);
            run_scan(which, h, pat, 4'b0000, 1'b1);
            repeat ($urandom_range(0, 3)) tick();
            consume_to_idle(which, pat);
        end
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_hold_out();
        test_back_to_back();
        test_async_reset();
        test_random();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d results never arrived", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
